// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: runs the reset / BAT / ID / stream-enable init sequence,
// then assembles 3-byte stream packets into button, movement and overflow fields.
module ps2_mouse_ctrl #(
    parameter int RSP_TIMEOUT = 25000000,
    parameter int PKT_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rda,
    input  logic [7:0] rx_data,
    input  logic       tx_sent,
    output logic       tx_req,
    output logic [7:0] tx_data,
    output logic       init_done,
    output logic       init_err,
    output logic       pkt_valid,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic [1:0] retry_cnt,
    output logic [2:0] state_dbg
);

    localparam int TMAX = (RSP_TIMEOUT > PKT_TIMEOUT) ? RSP_TIMEOUT : PKT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        SEND_RST   = 3'd0,
        WAIT_ACK_R = 3'd1,
        WAIT_BAT   = 3'd2,
        WAIT_ID    = 3'd3,
        SEND_EN    = 3'd4,
        WAIT_ACK_E = 3'd5,
        STREAM     = 3'd6,
        ERROR      = 3'd7
    } state_t;

    state_t        state, nxt;
    logic          rx_rda_q;
    logic          rx_new;
    logic [TW-1:0] timer;
    logic [1:0]    idx;
    logic [7:0]    byte0, byte1;
    logic          fail;
    logic          is_wait;
    logic          rsp_expired;
    logic          pkt_expired;

    assign rx_new      = rx_rda & ~rx_rda_q;
    assign is_wait     = (state == WAIT_ACK_R) || (state == WAIT_BAT) ||
                         (state == WAIT_ID) || (state == WAIT_ACK_E);
    assign rsp_expired = (timer == TW'(RSP_TIMEOUT - 1));
    assign pkt_expired = (idx != 2'd0) && (timer == TW'(PKT_TIMEOUT - 1));

    assign init_done = (state == STREAM);
    assign init_err  = (state == ERROR);
    assign state_dbg = state;

    always_comb begin
        nxt  = state;
        fail = 1'b0;
        case (state)
            SEND_RST: if (tx_sent && tx_req) nxt = WAIT_ACK_R;
            WAIT_ACK_R: begin
                // FE here is a resend request from the mouse, handled as a retry
                if (rx_new) begin
                    if (rx_data == 8'hFA) nxt = WAIT_BAT;
                    else                  fail = 1'b1;
                end else if (rsp_expired) fail = 1'b1;
            end
            WAIT_BAT: begin
                if (rx_new) begin
                    if (rx_data == 8'hAA) nxt = WAIT_ID;
                    else                  fail = 1'b1;
                end else if (rsp_expired) fail = 1'b1;
            end
            WAIT_ID: begin
                if (rx_new) begin
                    if (rx_data == 8'h00) nxt = SEND_EN;
                    else                  fail = 1'b1;
                end else if (rsp_expired) fail = 1'b1;
            end
            SEND_EN: if (tx_sent && tx_req) nxt = WAIT_ACK_E;
            WAIT_ACK_E: begin
                if (rx_new) begin
                    if (rx_data == 8'hFA)      nxt = STREAM;
                    else if (rx_data == 8'hFE) nxt = SEND_EN;
                    else                       fail = 1'b1;
                end else if (rsp_expired) fail = 1'b1;
            end
            default: nxt = state;
        endcase
        if (fail) nxt = (retry_cnt == 2'(MAX_RETRY)) ? ERROR : SEND_RST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEND_RST;
            rx_rda_q  <= 1'b0;
            tx_req    <= 1'b0;
            tx_data   <= 8'hFF;
            retry_cnt <= 2'd0;
            timer     <= '0;
            idx       <= 2'd0;
            byte0     <= 8'h00;
            byte1     <= 8'h00;
            pkt_valid <= 1'b0;
            buttons   <= 3'd0;
            dx        <= 9'd0;
            dy        <= 9'd0;
            x_ovf     <= 1'b0;
            y_ovf     <= 1'b0;
        end else begin
            state    <= nxt;
            rx_rda_q <= rx_rda;
            // Request stays up for the whole SEND_* visit and drops with tx_sent
            tx_req   <= (nxt == SEND_RST) || (nxt == SEND_EN);
            if (nxt != state) begin
                if (nxt == SEND_RST)     tx_data <= 8'hFF;
                else if (nxt == SEND_EN) tx_data <= 8'hF4;
            end
            if (fail && (retry_cnt != 2'(MAX_RETRY))) retry_cnt <= retry_cnt + 2'd1;

            if ((nxt != state) || rx_new)        timer <= '0;
            else if (state == STREAM)            timer <= ((idx == 2'd0) || pkt_expired) ? '0 : timer + 1'b1;
            else if (is_wait)                    timer <= timer + 1'b1;
            else                                 timer <= '0;

            pkt_valid <= 1'b0;
            if (state == STREAM) begin
                if (rx_new) begin
                    case (idx)
                        2'd0: if (rx_data[3]) begin
                            byte0 <= rx_data;
                            idx   <= 2'd1;
                        end
                        2'd1: begin
                            byte1 <= rx_data;
                            idx   <= 2'd2;
                        end
                        default: begin
                            buttons   <= byte0[2:0];
                            dx        <= {byte0[4], byte1};
                            dy        <= {byte0[5], rx_data};
                            x_ovf     <= byte0[6];
                            y_ovf     <= byte0[7];
                            pkt_valid <= 1'b1;
                            idx       <= 2'd0;
                        end
                    endcase
                end else if (pkt_expired) begin
                    idx <= 2'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Randomized bench for ps2_mouse_ctrl: init handshake, retries, resets and
// stream packet decode checked against a field-level packet model.
module tb_ps2_mouse_ctrl;

    localparam int RSP_TIMEOUT = 100;
    localparam int PKT_TIMEOUT = 20;
    localparam int MAX_RETRY   = 3;

    logic       clk = 1'b0;
    logic       rst, rx_rda, tx_sent;
    logic [7:0] rx_data;
    logic       tx_req, init_done, init_err, pkt_valid, x_ovf, y_ovf;
    logic [7:0] tx_data;
    logic [2:0] buttons, state_dbg;
    logic [8:0] dx, dy;
    logic [1:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sent_cyc = 0;
    int pkt_seen = 0;
    logic [22:0] exp_q[$];

    ps2_mouse_ctrl #(
        .RSP_TIMEOUT(RSP_TIMEOUT),
        .PKT_TIMEOUT(PKT_TIMEOUT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .rx_rda(rx_rda), .rx_data(rx_data), .tx_sent(tx_sent),
        .tx_req(tx_req), .tx_data(tx_data), .init_done(init_done), .init_err(init_err),
        .pkt_valid(pkt_valid), .buttons(buttons), .dx(dx), .dy(dy), .x_ovf(x_ovf),
        .y_ovf(y_ovf), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d checks, required completion", n_checks);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Reference packet: fields straight from the mouse packet definition
    function automatic logic [22:0] model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2);
        int xv, yv;
        logic [8:0] x9, y9;
        xv = b0[4] ? int'(b1) - 256 : int'(b1);
        yv = b0[5] ? int'(b2) - 256 : int'(b2);
        x9 = xv[8:0];
        y9 = yv[8:0];
        return {3'(b0 % 8), x9, y9, b0[6], b0[7]};
    endfunction

    // scoreboard
    always @(negedge clk) begin
        if (rst === 1'b0 && pkt_valid === 1'b1) begin
            pkt_seen++;
            if (exp_q.size() == 0) check("pkt_unexpected", 32'(exp_q.size()), 32'd1);
            else check("pkt", {9'd0, buttons, dx, dy, x_ovf, y_ovf}, {9'd0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic do_reset(input int n);
        @(posedge clk); #1 rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(posedge clk); #1 rx_data = b; rx_rda = 1'b1;
        repeat (hold) @(posedge clk);
        #1 rx_rda = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_q.push_back(model_pkt(b0, b1, b2));
        send_byte(b0, $urandom_range(1, 4));
        send_byte(b1, $urandom_range(1, 4));
        send_byte(b2, $urandom_range(1, 4));
    endtask

    task automatic do_tx(input string tag, input logic [7:0] exp_byte, output int gap);
        int w;
        w = 0;
        @(negedge clk);
        while (tx_req !== 1'b1 && w < 3 * RSP_TIMEOUT) begin
            @(negedge clk);
            w++;
        end
        gap = cyc - sent_cyc;
        check({tag, "_req"}, 32'(tx_req), 32'd1);
        if (tx_req === 1'b1) begin
            check({tag, "_data"}, 32'(tx_data), 32'(exp_byte));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check({tag, "_hold"}, {23'd0, tx_req, tx_data}, {23'd0, 1'b1, exp_byte});
            end
            @(posedge clk); #1 tx_sent = 1'b1;
            @(posedge clk); #1 tx_sent = 1'b0; sent_cyc = cyc;
            @(negedge clk);
            check({tag, "_drop"}, 32'(tx_req), 32'd0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_req"}, 32'(tx_req), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'hFF);
        check({tag, "_flags"}, {29'd0, init_done, init_err, pkt_valid}, 32'd0);
        check({tag, "_pkt_bus"}, {9'd0, buttons, dx, dy, x_ovf, y_ovf}, 32'd0);
        check({tag, "_retry"}, 32'(retry_cnt), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    task automatic do_init(input string tag);
        int g;
        do_tx({tag, "_ff"}, 8'hFF, g);
        send_byte(8'hFA, $urandom_range(1, 3));
        send_byte(8'hAA, $urandom_range(1, 3));
        send_byte(8'h00, $urandom_range(1, 3));
        do_tx({tag, "_f4"}, 8'hF4, g);
        send_byte(8'hFA, $urandom_range(1, 3));
        @(negedge clk);
        check({tag, "_done"}, {29'd0, init_done, init_err, retry_cnt}, {29'd0, 1'b1, 1'b0, 2'd0});
        check({tag, "_state"}, 32'(state_dbg), 32'd6);
    endtask

    initial begin
        int g, seen0, w, hi;
        logic [7:0] b0, b1, b2;
        rst = 1'b1; rx_rda = 1'b0; rx_data = 8'h00; tx_sent = 1'b0;
        do_reset(3);
        @(negedge clk);
        check_reset_vals("por");

        do_init("init");

        // directed decode, resync and stuck-level cases
        send_pkt(8'h39, 8'h05, 8'hF0);
        send_byte(8'h05, 2);
        send_pkt(8'h08, 8'h01, 8'h02);
        seen0 = pkt_seen;
        exp_q.push_back(model_pkt(8'h0C, 8'h03, 8'h0C));
        send_byte(8'h0C, 1);
        send_byte(8'h03, 2);
        send_byte(8'h0C, 50);
        repeat (5) @(negedge clk);
        check("stuck_one_pkt", 32'(pkt_seen - seen0), 32'd1);

        // partial packet expires before the next byte
        send_byte(8'h08, 1);
        send_byte(8'h10, 1);
        repeat (PKT_TIMEOUT + 5) @(posedge clk);
        send_pkt(8'h09, 8'h00, 8'h00);

        // randomized stream with junk bytes and abandoned packets
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) begin
                send_byte(8'($urandom_range(0, 255)) & 8'hF7, $urandom_range(1, 4));
            end else if (r == 2) begin
                send_byte(8'($urandom_range(0, 255)) | 8'h08, $urandom_range(1, 4));
                if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 255)), 1);
                repeat (PKT_TIMEOUT + 5) @(posedge clk);
            end
            b0 = 8'($urandom_range(0, 255)) | 8'h08;
            b1 = 8'($urandom_range(0, 255));
            b2 = 8'($urandom_range(0, 255));
            send_pkt(b0, b1, b2);
        end
        repeat (10) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset while requesting F4, then FE in WAIT_ACK_E
        do_reset(1);
        do_tx("mt_ff", 8'hFF, g);
        send_byte(8'hFA, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h00, 1);
        w = 0;
        @(negedge clk);
        while (tx_req !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("mt_en_req", {23'd0, tx_req, tx_data}, {23'd0, 1'b1, 8'hF4});
        do_reset(1);
        @(negedge clk);
        check_reset_vals("midtx");
        do_tx("mt_resend", 8'hFF, g);
        send_byte(8'hFA, 1);
        send_byte(8'hAA, 1);
        send_byte(8'h00, 1);
        do_tx("fe_f4", 8'hF4, g);
        send_byte(8'hFE, 1);
        do_tx("fe_resend", 8'hF4, g);
        check("fe_retry", 32'(retry_cnt), 32'd0);
        send_byte(8'hFA, 1);
        @(negedge clk);
        check("fe_done", 32'(init_done), 32'd1);

        // FE after reset command counts as a retry
        do_reset(1);
        do_tx("fer_ff", 8'hFF, g);
        send_byte(8'hFE, 1);
        check("fer_retry", 32'(retry_cnt), 32'd1);
        do_tx("fer_resend", 8'hFF, g);

        // no acknowledge at all: retries exhaust into ERROR
        do_reset(1);
        for (int i = 0; i <= MAX_RETRY; i++) begin
            do_tx("rt_ff", 8'hFF, g);
            if (i > 0) check("rt_gap", 32'(g >= RSP_TIMEOUT && g <= RSP_TIMEOUT + 2), 32'd1);
            check("rt_cnt", 32'(retry_cnt), 32'(i));
        end
        repeat (RSP_TIMEOUT + 5) @(negedge clk);
        check("err_state", {27'd0, state_dbg, init_err, init_done}, {27'd0, 3'd7, 1'b1, 1'b0});
        check("err_retry", 32'(retry_cnt), 32'(MAX_RETRY));
        send_byte(8'hFA, 1);
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_req !== 1'b0) hi++;
        end
        check("err_no_tx", 32'(hi), 32'd0);
        check("err_stays", 32'(state_dbg), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
